// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - request FIFO feeding alu_4bit with a registered, handshaked result slot
// Define ALU_ISSUE_STATS_EN to add saturating stat_issued/stat_carry counters.
module alu_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 4,
  parameter int OP_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  input  logic [OP_W-1:0]          in_opcode,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [OP_W-1:0]          alu_opcode,
  input  logic [DATA_W-1:0]        alu_results,
  input  logic                     alu_zero_flag,
  input  logic                     alu_carry_flag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_results,
  output logic                     out_zero_flag,
  output logic                     out_carry_flag,
  output logic [OP_W-1:0]          out_opcode,
  output logic [$clog2(DEPTH):0]   count
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [7:0]               stat_issued,
  output logic [7:0]               stat_carry
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  slot_e slot_q, slot_d;

  logic [DATA_W-1:0] mem_a_q  [DEPTH];
  logic [DATA_W-1:0] mem_b_q  [DEPTH];
  logic [OP_W-1:0]   mem_op_q [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [DATA_W-1:0] res_q, res_d;
  logic              zf_q, zf_d;
  logic              cf_q, cf_d;
  logic [OP_W-1:0]   op_q, op_d;

  logic              not_empty;
  logic              push;
  logic              pop_en;

  // in_ready depends only on registered occupancy, so a full queue never
  // accepts a push even in a cycle where it also pops.
  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q < DEPTH_C);
  assign push      = in_valid && in_ready;
  assign pop_en    = not_empty && ((slot_q == SLOT_EMPTY) || out_ready);

  assign alu_a      = not_empty ? mem_a_q[rd_ptr_q]  : '0;
  assign alu_b      = not_empty ? mem_b_q[rd_ptr_q]  : '0;
  assign alu_opcode = not_empty ? mem_op_q[rd_ptr_q] : '0;

  assign out_valid      = (slot_q == SLOT_FULL);
  assign out_results    = res_q;
  assign out_zero_flag  = zf_q;
  assign out_carry_flag = cf_q;
  assign out_opcode     = op_q;
  assign count          = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    slot_d = slot_q;
    res_d  = res_q;
    zf_d   = zf_q;
    cf_d   = cf_q;
    op_d   = op_q;
    case (slot_q)
      SLOT_EMPTY: begin
        if (pop_en) begin
          slot_d = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (pop_en) begin
          slot_d = SLOT_FULL;
        end else if (out_ready) begin
          slot_d = SLOT_EMPTY;
        end
      end
      default: slot_d = SLOT_EMPTY;
    endcase
    // The ALU is combinational on the head entry, so its outputs this cycle
    // belong to the entry being popped.
    if (pop_en) begin
      res_d = alu_results;
      zf_d  = alu_zero_flag;
      cf_d  = alu_carry_flag;
      op_d  = mem_op_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= SLOT_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      res_q    <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      op_q     <= '0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      res_q    <= res_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      op_q     <= op_d;
    end
  end

  // Entry storage needs no reset: it is only observed while count > 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q]  <= in_a;
      mem_b_q[wr_ptr_q]  <= in_b;
      mem_op_q[wr_ptr_q] <= in_opcode;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [7:0] stat_issued_q, stat_issued_d;
  logic [7:0] stat_carry_q, stat_carry_d;

  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_carry_d  = stat_carry_q;
    if (pop_en && (stat_issued_q != 8'hFF)) begin
      stat_issued_d = stat_issued_q + 8'd1;
    end
    if (pop_en && alu_carry_flag && (stat_carry_q != 8'hFF)) begin
      stat_carry_d = stat_carry_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_q <= 8'd0;
      stat_carry_q  <= 8'd0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_carry_q  <= stat_carry_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_carry  = stat_carry_q;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - directed bench for alu_issue_queue with a behavioural 4-bit ALU on the alu_* ports
module tb_alu_issue_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_opcode;
  logic [3:0] alu_results;
  logic       alu_zero_flag;
  logic       alu_carry_flag;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_results;
  logic       out_zero_flag;
  logic       out_carry_flag;
  logic [2:0] out_opcode;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(4), .DATA_W(4), .OP_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_opcode      (in_opcode),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_opcode     (alu_opcode),
    .alu_results    (alu_results),
    .alu_zero_flag  (alu_zero_flag),
    .alu_carry_flag (alu_carry_flag),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_results    (out_results),
    .out_zero_flag  (out_zero_flag),
    .out_carry_flag (out_carry_flag),
    .out_opcode     (out_opcode),
    .count          (count)
  );

  // Behavioural stand-in for alu_4bit
  logic [4:0] alu_wide;
  always_comb begin
    alu_wide = 5'd0;
    case (alu_opcode)
      3'b000:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010:  alu_wide = {1'b0, alu_a & alu_b};
      3'b011:  alu_wide = {1'b0, alu_a | alu_b};
      3'b100:  alu_wide = {1'b0, alu_a ^ alu_b};
      default: alu_wide = {1'b0, alu_a};
    endcase
  end
  assign alu_results    = alu_wide[3:0];
  assign alu_carry_flag = alu_wide[4];
  assign alu_zero_flag  = (alu_wide[3:0] == 4'd0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_a = 4'd5; in_b = 4'd6; in_opcode = 3'b000; out_ready = 1'b1;
    step();
    step();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (out_results !== 4'd0) begin fails++; $display("FAIL reset_out_results got %0d exp 0", out_results); end
    tests++; if (alu_a !== 4'd0) begin fails++; $display("FAIL reset_alu_a got %0d exp 0", alu_a); end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_single_add();
    in_valid = 1'b1; in_a = 4'b0010; in_b = 4'b0001; in_opcode = 3'b000; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_latency_valid got %b exp 0", out_valid); end
    tests++; if (alu_a !== 4'b0010 || alu_b !== 4'b0001) begin fails++; $display("FAIL add_head got a=%0d b=%0d exp a=2 b=1", alu_a, alu_b); end
    step();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_valid got %b exp 1", out_valid); end
    tests++; if (out_results !== 4'b0011) begin fails++; $display("FAIL add_results got %0d exp 3", out_results); end
    tests++; if (out_zero_flag !== 1'b0 || out_carry_flag !== 1'b0) begin fails++; $display("FAIL add_flags got z=%b c=%b exp z=0 c=0", out_zero_flag, out_carry_flag); end
    tests++; if (out_opcode !== 3'b000) begin fails++; $display("FAIL add_opcode got %0d exp 0", out_opcode); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_wrap_zero();
    in_valid = 1'b1; in_a = 4'b1111; in_b = 4'b0001; in_opcode = 3'b000; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b1 || out_results !== 4'b0000) begin fails++; $display("FAIL wrap_results got v=%b r=%0d exp v=1 r=0", out_valid, out_results); end
    tests++; if (out_zero_flag !== 1'b1) begin fails++; $display("FAIL wrap_zero got %b exp 1", out_zero_flag); end
    tests++; if (out_carry_flag !== 1'b1) begin fails++; $display("FAIL wrap_carry got %b exp 1", out_carry_flag); end
    step();
  endtask

  task automatic test_backpressure();
    // Requests r0..r5 are A=i+1, B=2, ADD, so result i+3
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 4'(i + 1); in_b = 4'd2; in_opcode = 3'b000;
      step();
    end
    in_a = 4'd6; in_b = 4'd2;
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL bp_full_count got %0d exp 4", count); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    tests++; if (out_valid !== 1'b1 || out_results !== 4'd3) begin fails++; $display("FAIL bp_slot got v=%b r=%0d exp v=1 r=3", out_valid, out_results); end
    step();
    step();
    tests++; if (count !== 3'd4 || out_results !== 4'd3 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold got count=%0d r=%0d v=%b exp 4 3 1", count, out_results, out_valid); end
    out_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      step();
      tests++; if (out_valid !== 1'b1 || out_results !== 4'(j + 3)) begin fails++; $display("FAIL bp_drain_%0d got v=%b r=%0d exp v=1 r=%0d", j, out_valid, out_results, j + 3); end
      if (j == 2) begin
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL bp_push_pop_count got %0d exp 3", count); end
        in_valid = 1'b0;
      end
    end
    step();
    tests++; if (out_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL bp_empty got v=%b count=%0d exp 0 0", out_valid, count); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = 4'(i); in_b = 4'd1; in_opcode = 3'b000;
      step();
      tests++; if (count > 3'd1) begin fails++; $display("FAIL stream_count_%0d got %0d exp <=1", i, count); end
      if (i > 0) begin
        tests++; if (out_valid !== 1'b1 || out_results !== 4'(i)) begin fails++; $display("FAIL stream_res_%0d got v=%b r=%0d exp v=1 r=%0d", i, out_valid, out_results, i); end
      end
    end
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b1 || out_results !== 4'd8 || count !== 3'd0) begin fails++; $display("FAIL stream_last got v=%b r=%0d count=%0d exp 1 8 0", out_valid, out_results, count); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 4'(i + 10); in_b = 4'd0; in_opcode = 3'b000;
      step();
    end
    in_valid = 1'b0;
    tests++; if (count !== 3'd3 || out_valid !== 1'b1) begin fails++; $display("FAIL mid_pre got count=%0d v=%b exp 3 1", count, out_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL mid_cleared got count=%0d v=%b exp 0 0", count, out_valid); end
    tests++; if (out_results !== 4'd0 || alu_a !== 4'd0) begin fails++; $display("FAIL mid_zeroed got r=%0d alu_a=%0d exp 0 0", out_results, alu_a); end
    out_ready = 1'b1; in_valid = 1'b1; in_a = 4'd6; in_b = 4'd3; in_opcode = 3'b000;
    step();
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b1 || out_results !== 4'd9) begin fails++; $display("FAIL mid_new got v=%b r=%0d exp 1 9", out_valid, out_results); end
    step();
    tests++; if (out_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL mid_no_stale got v=%b count=%0d exp 0 0", out_valid, count); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0; in_opcode = 3'd0; out_ready = 1'b0;
    #2;
    test_reset();
    test_single_add();
    test_wrap_zero();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
